// File: rtl/radix4_divider_unit.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_divider_unit
//  Description : Unsigned iterative radix-4 restoring divider. Resolves two
//                quotient bits per cycle and returns quotient/remainder with
//                a one-cycle output_valid_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             input_valid_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             output_valid_o,
  output logic             busy_o
);

  localparam int         CNT_W     = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  localparam int         PW        = WIDTH + 2;
  localparam [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;

  logic [WIDTH-1:0] r_dvd;       // dividend, consumed two MSBs per step
  logic [WIDTH-1:0] r_div;       // latched divisor
  logic [PW-1:0]    r_d3;        // 3*divisor, formed once at accept
  logic [PW-1:0]    r_p;         // partial remainder
  logic [WIDTH-1:0] r_q;         // quotient under construction
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [PW-1:0]    w_d1;
  logic [PW-1:0]    w_d2;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_p_next;
  logic [1:0]       w_digit;
  logic [WIDTH-1:0] w_q_next;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a request is taken whenever the unit is not calculating
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (input_valid_i) begin
          w_state_next = ST_CALC;
          w_accept     = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_d1 = {2'b00, r_div};
  assign w_d2 = {1'b0, r_div, 1'b0};
  assign w_pp = {r_p[WIDTH-1:0], r_dvd[WIDTH-1 -: 2]};

  // One restoring radix-4 step: pick the largest multiple that fits.
  // With a zero divisor every multiple is zero, so the digit saturates at 3.
  always_comb begin
    w_digit  = 2'd0;
    w_p_next = w_pp;
    if (w_pp >= r_d3) begin
      w_digit  = 2'd3;
      w_p_next = w_pp - r_d3;
    end else if (w_pp >= w_d2) begin
      w_digit  = 2'd2;
      w_p_next = w_pp - w_d2;
    end else if (w_pp >= w_d1) begin
      w_digit  = 2'd1;
      w_p_next = w_pp - w_d1;
    end
  end

  assign w_q_next = (r_q << 2) | WIDTH'(w_digit);

  // Datapath: latch operands on accept, iterate in CALC, publish on the last step
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dvd       <= '0;
      r_div       <= '0;
      r_d3        <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_dvd <= dividend_i;
      r_div <= divisor_i;
      r_d3  <= {2'b00, divisor_i} + {1'b0, divisor_i, 1'b0};
      r_p   <= '0;
      r_q   <= '0;
      r_cnt <= C_CNT_INIT;
    end else if (r_state == ST_CALC) begin
      r_dvd <= r_dvd << 2;
      r_p   <= w_p_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_p_next[WIDTH-1:0];
      end
    end
  end

  assign quotient_o     = r_quotient;
  assign remainder_o    = r_remainder;
  assign output_valid_o = (r_state == ST_DONE);
  assign busy_o         = (r_state == ST_CALC);

endmodule
`default_nettype wire

// File: tb/tb_radix4_divider_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radix4_divider_unit
//  Description : Self-checking bench for radix4_divider_unit (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_divider_unit;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             input_valid_i = 1'b0;
  logic [WIDTH-1:0] dividend_i = '0;
  logic [WIDTH-1:0] divisor_i = '0;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             output_valid_o;
  logic             busy_o;

  int errors = 0;
  int checks = 0;

  radix4_divider_unit #(.WIDTH(WIDTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .input_valid_i  (input_valid_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .quotient_o     (quotient_o),
    .remainder_o    (remainder_o),
    .output_valid_o (output_valid_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain integer division; a zero divisor yields all ones / dividend
  function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? '1 : a / b;
  endfunction

  function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Drive a request through the cycle-0 edge; returns sitting in cycle 1
  task automatic start_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    input_valid_i = 1'b1;
    dividend_i    = a;
    divisor_i     = b;
    @(posedge clk_i); #1;
    input_valid_i = 1'b0;
  endtask

  // Called in cycle 1; expects the pulse in cycle 17 and none in cycle 18.
  // With chain set, a new request is presented during the DONE cycle.
  task automatic wait_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input string nm, input bit chain,
                             input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
    int cyc;
    bit seen;
    logic [WIDTH-1:0] eq, er;
    cyc  = 1;
    seen = 1'b0;
    eq   = ref_q(a, b);
    er   = ref_r(a, b);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_cycle1: got %b want 1", nm, busy_o);
    end
    while (cyc <= 40) begin
      if (output_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    checks++;
    if (!seen || cyc != 17) begin
      errors++;
      $display("FAIL %s latency: got cycle %0d (seen=%0b) want 17", nm, cyc, seen);
    end
    if (seen) begin
      checks++;
      if (quotient_o !== eq) begin
        errors++;
        $display("FAIL %s quotient: %0d/%0d got %h want %h", nm, a, b, quotient_o, eq);
      end
      checks++;
      if (remainder_o !== er) begin
        errors++;
        $display("FAIL %s remainder: %0d/%0d got %h want %h", nm, a, b, remainder_o, er);
      end
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_in_done: got %b want 0", nm, busy_o);
      end
    end
    if (chain) begin
      input_valid_i = 1'b1;
      dividend_i    = na;
      divisor_i     = nb;
    end
    @(posedge clk_i); #1;
    input_valid_i = 1'b0;
    checks++;
    if (output_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: got %b in cycle 18 want 0", nm, output_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({output_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b want 0 0", output_valid_o, busy_o);
    end
    checks++;
    if (quotient_o !== '0 || remainder_o !== '0) begin
      errors++;
      $display("FAIL reset_results: got q=%h r=%h want 0 0", quotient_o, remainder_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    start_req(32'd100, 32'd7);
    wait_result(32'd100, 32'd7, "div_100_7", 1'b0, '0, '0);
    start_req(32'hFFFF_FFFF, 32'd1);
    wait_result(32'hFFFF_FFFF, 32'd1, "div_max_1", 1'b0, '0, '0);
    start_req(32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(32'h8000_0000, 32'hFFFF_FFFF, "div_msb_max", 1'b0, '0, '0);
    start_req(32'h1234, 32'd0);
    wait_result(32'h1234, 32'd0, "div_by_zero", 1'b0, '0, '0);
  endtask

  task automatic test_ignore_in_calc();
    int pulses;
    int at;
    logic [WIDTH-1:0] gq, gr;
    pulses = 0;
    at     = 0;
    gq     = '0;
    gr     = '0;
    start_req(32'd50, 32'd5);
    for (int c = 1; c <= 40; c++) begin
      if (c >= 5 && c <= 8) begin
        input_valid_i = 1'b1;
        dividend_i    = 32'd9;
        divisor_i     = 32'd2;
      end else begin
        input_valid_i = 1'b0;
      end
      if (output_valid_o === 1'b1) begin
        pulses++;
        at = c;
        gq = quotient_o;
        gr = remainder_o;
      end
      @(posedge clk_i); #1;
    end
    input_valid_i = 1'b0;
    checks++;
    if (pulses != 1 || at != 17) begin
      errors++;
      $display("FAIL ignore_calc_pulse: got %0d pulses last at %0d want 1 at 17", pulses, at);
    end
    checks++;
    if (gq !== 32'd10 || gr !== 32'd0) begin
      errors++;
      $display("FAIL ignore_calc_result: got q=%0d r=%0d want 10 0", gq, gr);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    start_req(32'd1000, 32'd3);
    repeat (7) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if ({output_valid_o, busy_o} !== 2'b00 || quotient_o !== '0 || remainder_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b b=%b q=%h r=%h want all 0",
               output_valid_o, busy_o, quotient_o, remainder_o);
    end
    rst_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (output_valid_o === 1'b1) pulses++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    start_req(32'd7, 32'd2);
    wait_result(32'd7, 32'd2, "b2b_first", 1'b1, 32'hFFFF, 32'h10);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_in_done: busy got %b want 1", busy_o);
    end
    wait_result(32'hFFFF, 32'h10, "b2b_second", 1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom_range(1, 15);
        1:       b = $urandom & 32'hFFFF;
        2:       b = (i % 50 == 0) ? 32'd0 : $urandom;
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      start_req(a, b);
      wait_result(a, b, "random", 1'b0, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_in_calc();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
